add16u_err_monitor: RTL and testbench
=====================================

# add16u_err_monitor

Streaming error-characterisation stage that sits directly downstream of a W-bit unsigned approximate adder. Each accepted sample carries the adder operands and the adder's (W+1)-bit result. The block recomputes the exact sum and accumulates worst-case error, sum of absolute error, signed error sum and error count over a programmed batch of samples. It gives on-chip MAE/WCE/EP figures for FPGA characterisation runs.

## Interface
- W, 16, operand width; approximate result is W+1 bits
- CNT_W, 32, width of sample/error counters and n_samples
- ACC_W, 48, width of error-sum accumulators
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a batch; honoured only in IDLE
- n_samples  in  CNT_W  batch length, sampled on accepted start
- in_valid  in  1  sample present
- in_ready  out  1  block accepts sample this cycle
- in_a, in_b  in  W  adder operands
- in_approx  in  W+1  approximate adder result for in_a, in_b
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse when batch results are final
- sample_cnt  out  CNT_W  samples accumulated
- err_cnt  out  CNT_W  samples with nonzero error
- wce  out  W+1  max |error|
- sae  out  ACC_W  sum of |error|, saturating
- sse  out  ACC_W  signed sum of error (two's complement), saturating at signed limits

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- Start handling (IDLE only):
  - start=1 latches n_samples and clears sample_cnt, err_cnt, wce, sae and sse to 0.
  - n_samples=0 goes to DONE; otherwise goes to RUN.
  - start outside IDLE is ignored.
- RUN:
  - in_ready=1 while accepted<n_samples.
  - A transfer occurs when in_valid&in_ready.
  - The transfer that makes accepted==n_samples moves to DRAIN.
- DRAIN: in_ready=0. Goes to DONE when the pipeline holds no valid sample.
- DONE: done=1 for exactly one cycle, then IDLE.
- Results hold until the next accepted start.
- Pipeline:
  - S1 registers a, b, approx and a valid bit.
  - S2 computes exact=a+b (W+1 bits), err=approx−exact as a (W+2)-bit signed value, abs=|err| as W+1 bits unsigned, then updates the accumulators:
    - sample_cnt += 1
    - err_cnt += (err≠0)
    - wce = max(wce, abs)
    - sae += abs
    - sse += sign-extended err
- No truncation anywhere before the accumulators.
- Saturation: sae clamps at 2^ACC_W−1. sse clamps at +2^(ACC_W−1)−1 / −2^(ACC_W−1). Once clamped, a value stays clamped until the next clear.
- Counters cannot overflow because they are bounded by n_samples.
- in_valid while in_ready=0 is ignored; there is no buffering.

## Timing
- Reset values:
  - state=IDLE
  - in_ready=0, busy=0, done=0
  - all result outputs 0
  - pipeline valid bits 0
- Reset mid-batch aborts the batch immediately (asynchronous); no done is issued.
- Latency: a sample accepted at edge k is reflected in the outputs after edge k+2.
- DONE is entered on the edge after the last sample's accumulator update, so done is asserted at k_last+3.
- in_ready is registered-state driven; it is not combinationally dependent on in_valid.
- Full-rate operation: one sample per cycle, with no bubbles required.
- For n_samples=0, done is asserted in the cycle after start.
- start and in_valid in the same IDLE cycle: the sample is not accepted (in_ready=0 in IDLE).

## Test plan
- Reset/idle:
  - Stimulus: assert rst_n=0 mid-RUN, release, hold in_valid=1.
  - Required: all outputs 0, in_ready=0, done never pulses, no accumulation.
- Mixed batch, n_samples=3, samples:
  - (a=0, b=0, approx=34), error +34
  - (a=100, b=50, approx=140), error −10
  - (a=65535, b=65535, approx=131070), error 0
  - Required: done, then sample_cnt=3, err_cnt=2, wce=34, sae=44, sse=24.
- Exact-only batch:
  - Stimulus: n_samples=1000, random operands, approx=a+b.
  - Required: sample_cnt=1000, err_cnt=0, wce=0, sae=0, sse=0.
- Backpressure and latency:
  - Stimulus: n_samples=4 with in_valid toggling every other cycle.
  - Required: exactly 4 transfers; in_ready drops after the 4th; done asserted 3 cycles after the 4th transfer; extra valids ignored.
- Boundary conditions:
  - n_samples=0: done one cycle after start, all results 0.
  - start while busy: ignored.
  - Extremes: approx=131071, a=b=0 → wce=131071. approx=0, a=b=65535 → err=−131070, sse=−131070.
- Saturation:
  - Stimulus: ACC_W=18 build, 3 samples with |err|=131071.
  - Required: sae=262143 (clamped); sse clamped at +131071.

Source files
------------

// File: rtl/add16u_err_monitor_if.sv
// Sample/control bundle between a characterisation driver and add16u_err_monitor.
// A sample transfers on a rising clk edge where in_valid && in_ready; in_ready comes from registered state only, and in_valid offered while in_ready is low is dropped, never buffered.
interface add16u_err_monitor_if #(
  parameter int W     = 16,
  parameter int CNT_W = 32,
  parameter int ACC_W = 48
) ();
  logic             start;
  logic [CNT_W-1:0] n_samples;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [W:0]       in_approx;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [W:0]       wce;
  logic [ACC_W-1:0] sae;
  logic [ACC_W-1:0] sse;

  modport master (
    output start, n_samples, in_valid, in_a, in_b, in_approx,
    input  in_ready, busy, done, sample_cnt, err_cnt, wce, sae, sse
  );

  modport slave (
    input  start, n_samples, in_valid, in_a, in_b, in_approx,
    output in_ready, busy, done, sample_cnt, err_cnt, wce, sae, sse
  );
endinterface

// File: rtl/add16u_err_monitor.sv
// Error characterisation for a W-bit unsigned approximate adder: recomputes the exact sum
// and accumulates sample count, error count, worst-case error, saturating |err| and signed err sums.
module add16u_err_monitor #(
  parameter int W     = 16,
  parameter int CNT_W = 32,
  parameter int ACC_W = 48
) (
  input  logic                 clk,
  input  logic                 rst_n,
  add16u_err_monitor_if.slave  bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam int SEXT_W = ACC_W + 1 - (W + 2);

  state_t state, state_nxt;
  logic   ready_c, busy_c, done_c;

  logic [CNT_W-1:0] n_lat;
  logic [CNT_W-1:0] accepted;
  logic             xfer;
  logic             start_ok;

  logic             s1_valid;
  logic [W-1:0]     s1_a;
  logic [W-1:0]     s1_b;
  logic [W:0]       s1_approx;

  logic [W:0]        exact_c;
  logic signed [W+1:0] err_c;
  logic signed [W+1:0] neg_err_c;
  logic [W:0]        abs_c;

  logic                s2_valid;
  logic signed [W+1:0] s2_err;
  logic [W:0]          s2_abs;

  logic [CNT_W-1:0] sample_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [W:0]       wce_q;
  logic [ACC_W-1:0] sae_q;
  logic [ACC_W-1:0] sse_q;
  logic             sae_sat;
  logic             sse_sat;

  logic [ACC_W:0]   sae_sum;
  logic [ACC_W:0]   sse_sum;

  assign xfer     = bus.in_valid & ready_c;
  assign start_ok = (state == S_IDLE) & bus.start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) state_nxt = (bus.n_samples == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        ready_c = 1'b1;
        busy_c  = 1'b1;
        if (bus.in_valid && (accepted == n_lat - CNT_W'(1))) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy_c = 1'b1;
        if (!s1_valid && !s2_valid) state_nxt = S_DONE;
      end
      S_DONE: begin
        done_c    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_lat    <= '0;
      accepted <= '0;
    end else if (start_ok) begin
      n_lat    <= bus.n_samples;
      accepted <= '0;
    end else if (xfer) begin
      accepted <= accepted + CNT_W'(1);
    end
  end

  // S1: capture the accepted sample as-is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_approx <= '0;
    end else begin
      s1_valid <= xfer;
      if (xfer) begin
        s1_a      <= bus.in_a;
        s1_b      <= bus.in_b;
        s1_approx <= bus.in_approx;
      end
    end
  end

  // Error is computed one bit wider than the sum so approx-exact never wraps.
  assign exact_c   = {1'b0, s1_a} + {1'b0, s1_b};
  assign err_c     = $signed({1'b0, s1_approx}) - $signed({1'b0, exact_c});
  assign neg_err_c = -err_c;
  assign abs_c     = err_c[W+1] ? neg_err_c[W:0] : err_c[W:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_err   <= '0;
      s2_abs   <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_err <= err_c;
        s2_abs <= abs_c;
      end
    end
  end

  assign sae_sum = {1'b0, sae_q} + (ACC_W+1)'(s2_abs);
  assign sse_sum = {sse_q[ACC_W-1], sse_q} + {{SEXT_W{s2_err[W+1]}}, s2_err};

  // Sticky saturation: a clamped sum ignores later samples until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      wce_q        <= '0;
      sae_q        <= '0;
      sse_q        <= '0;
      sae_sat      <= 1'b0;
      sse_sat      <= 1'b0;
    end else if (start_ok) begin
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      wce_q        <= '0;
      sae_q        <= '0;
      sse_q        <= '0;
      sae_sat      <= 1'b0;
      sse_sat      <= 1'b0;
    end else if (s2_valid) begin
      sample_cnt_q <= sample_cnt_q + CNT_W'(1);
      if (s2_err != '0) err_cnt_q <= err_cnt_q + CNT_W'(1);
      if (s2_abs > wce_q) wce_q <= s2_abs;
      if (!sae_sat) begin
        if (sae_sum[ACC_W]) begin
          sae_q   <= '1;
          sae_sat <= 1'b1;
        end else begin
          sae_q <= sae_sum[ACC_W-1:0];
        end
      end
      if (!sse_sat) begin
        if (sse_sum[ACC_W] != sse_sum[ACC_W-1]) begin
          sse_q   <= sse_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
          sse_sat <= 1'b1;
        end else begin
          sse_q <= sse_sum[ACC_W-1:0];
        end
      end
    end
  end

  assign bus.in_ready   = ready_c;
  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.sample_cnt = sample_cnt_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.wce        = wce_q;
  assign bus.sae        = sae_q;
  assign bus.sse        = sse_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_add16u_err_monitor.sv
// Bench for add16u_err_monitor: a 48-bit and an 18-bit accumulator build share one stimulus
// stream; results are compared against an integer reference model over the accepted samples.
module tb_add16u_err_monitor;
  localparam int W     = 16;
  localparam int CNT_W = 32;
  localparam int ACC_W = 48;
  localparam int ACC_S = 18;
  localparam int SW    = 3 * W + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] dbg_state, dbg_state_s;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int start_cyc = 0;
  int done_cnt = 0;

  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] stim_q[$];

  add16u_err_monitor_if #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_W)) bus ();
  add16u_err_monitor_if #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_S)) bus_s ();

  add16u_err_monitor #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_state(dbg_state)
  );
  add16u_err_monitor #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_S)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(bus_s), .dbg_state(dbg_state_s)
  );

  assign bus_s.start     = bus.start;
  assign bus_s.n_samples = bus.n_samples;
  assign bus_s.in_valid  = bus.in_valid;
  assign bus_s.in_a      = bus.in_a;
  assign bus_s.in_b      = bus.in_b;
  assign bus_s.in_approx = bus.in_approx;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Monitor: records every transfer the bench sees on the handshake.
  always @(posedge clk) begin
    cyc++;
    if (rst_n && bus.in_valid && bus.in_ready) begin
      exp_q.push_back({bus.in_a, bus.in_b, bus.in_approx});
      last_acc_cyc = cyc;
    end
    if (rst_n && bus.start) start_cyc = cyc;
  end

  always @(negedge clk) if (bus.done) done_cnt++;

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model(input int acc_w, output longint sc, output longint ec,
                       output longint wc, output longint sa, output longint ss);
    longint sae_max, sse_max, sse_min, a, b, ap, e, ab;
    bit sa_clamped, ss_clamped;
    sae_max = (longint'(1) << acc_w) - 1;
    sse_max = (longint'(1) << (acc_w - 1)) - 1;
    sse_min = -(longint'(1) << (acc_w - 1));
    sc = 0; ec = 0; wc = 0; sa = 0; ss = 0;
    sa_clamped = 0; ss_clamped = 0;
    foreach (exp_q[i]) begin
      a  = longint'(exp_q[i][SW-1 -: W]);
      b  = longint'(exp_q[i][W+W : W+1]);
      ap = longint'(exp_q[i][W:0]);
      e  = ap - (a + b);
      ab = (e < 0) ? -e : e;
      sc++;
      if (e != 0) ec++;
      if (ab > wc) wc = ab;
      if (!sa_clamped) begin
        sa += ab;
        if (sa > sae_max) begin sa = sae_max; sa_clamped = 1; end
      end
      if (!ss_clamped) begin
        ss += e;
        if (ss > sse_max) begin ss = sse_max; ss_clamped = 1; end
        else if (ss < sse_min) begin ss = sse_min; ss_clamped = 1; end
      end
    end
  endtask

  task automatic verify(input string tag, input int n);
    longint sc, ec, wc, sa, ss;
    check({tag, ".xfers"}, exp_q.size(), n);
    model(ACC_W, sc, ec, wc, sa, ss);
    check({tag, ".sample_cnt"}, bus.sample_cnt, sc);
    check({tag, ".err_cnt"}, bus.err_cnt, ec);
    check({tag, ".wce"}, bus.wce, wc);
    check({tag, ".sae"}, bus.sae, sa);
    check({tag, ".sse"}, longint'($signed(bus.sse)), ss);
    model(ACC_S, sc, ec, wc, sa, ss);
    check({tag, ".s18.sample_cnt"}, bus_s.sample_cnt, sc);
    check({tag, ".s18.wce"}, bus_s.wce, wc);
    check({tag, ".s18.sae"}, bus_s.sae, sa);
    check({tag, ".s18.sse"}, longint'($signed(bus_s.sse)), ss);
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [SW-1:0] rnd_sample(input bit exact);
    logic [W-1:0] a, b;
    logic [W:0] ap;
    int s;
    a = W'($urandom_range(0, 65535));
    b = W'($urandom_range(0, 65535));
    if (exact) ap = {1'b0, a} + {1'b0, b};
    else if ($urandom_range(0, 1) == 1) ap = (W+1)'($urandom_range(0, 131071));
    else begin
      s = int'(a) + int'(b) + int'($urandom_range(0, 64)) - 32;
      if (s < 0) s = 0;
      if (s > 131071) s = 131071;
      ap = (W+1)'(s);
    end
    return {a, b, ap};
  endfunction

  task automatic start_batch(input int n);
    @(negedge clk);
    exp_q.delete();
    bus.n_samples = CNT_W'(n);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic feed(input bit toggle);
    int guard = 0;
    bit phase = 0;
    bit go;
    while (stim_q.size() > 0 && guard < 20000) begin
      phase = ~phase;
      if (toggle && !phase) bus.in_valid = 1'b0;
      else begin
        {bus.in_a, bus.in_b, bus.in_approx} = stim_q[0];
        bus.in_valid = 1'b1;
      end
      go = bus.in_valid && bus.in_ready;
      @(negedge clk);
      guard++;
      if (go) void'(stim_q.pop_front());
    end
    bus.in_valid = 1'b0;
    check("feed.drained", stim_q.size(), 0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (!bus.done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, ".done_seen"}, bus.done, 1);
  endtask

  task automatic finish_done(input string tag, input int cnt_before);
    @(negedge clk);
    #1;
    check({tag, ".done_width"}, bus.done, 0);
    check({tag, ".done_pulses"}, done_cnt - cnt_before, 1);
    check({tag, ".busy_after"}, bus.busy, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int dc;
    bus.start = 0; bus.n_samples = '0; bus.in_valid = 0;
    bus.in_a = '0; bus.in_b = '0; bus.in_approx = '0;
    repeat (3) @(negedge clk);
    check("rst.in_ready", bus.in_ready, 0);
    check("rst.busy", bus.busy, 0);
    check("rst.done", bus.done, 0);
    check("rst.sample_cnt", bus.sample_cnt, 0);
    check("rst.wce", bus.wce, 0);
    check("rst.sae", bus.sae, 0);
    check("rst.sse", bus.sse, 0);
    check("rst.state", dbg_state, 0);
    rst_n = 1'b1;

    // Mixed batch with hand-computed results.
    stim_q = '{{16'd0, 16'd0, 17'd34}, {16'd100, 16'd50, 17'd140}, {16'd65535, 16'd65535, 17'd131070}};
    dc = done_cnt;
    start_batch(3);
    feed(0);
    wait_done("mixed", 50);
    verify("mixed", 3);
    check("mixed.err_cnt_k", bus.err_cnt, 2);
    check("mixed.wce_k", bus.wce, 34);
    check("mixed.sae_k", bus.sae, 44);
    check("mixed.sse_k", longint'($signed(bus.sse)), 24);
    finish_done("mixed", dc);
    repeat (3) @(negedge clk);
    check("mixed.hold_sae", bus.sae, 44);

    // Exact-only batch at full rate.
    for (int i = 0; i < 1000; i++) stim_q.push_back(rnd_sample(1));
    dc = done_cnt;
    start_batch(1000);
    feed(0);
    wait_done("exact", 50);
    verify("exact", 1000);
    check("exact.err_cnt_k", bus.err_cnt, 0);
    finish_done("exact", dc);

    // Backpressure: valid every other cycle, then extra valids while draining.
    for (int i = 0; i < 4; i++) stim_q.push_back(rnd_sample(0));
    dc = done_cnt;
    start_batch(4);
    feed(1);
    check("bp.ready_drop", bus.in_ready, 0);
    bus.in_valid = 1'b1;
    wait_done("bp", 20);
    check("bp.done_latency", cyc - last_acc_cyc, 3);
    verify("bp", 4);
    finish_done("bp", dc);
    bus.in_valid = 1'b0;

    // Zero-length batch.
    dc = done_cnt;
    start_batch(0);
    check("n0.done", bus.done, 1);
    check("n0.latency", cyc - start_cyc, 0);
    verify("n0", 0);
    finish_done("n0", dc);

    // Start held high while busy must not restart the batch.
    for (int i = 0; i < 6; i++) stim_q.push_back(rnd_sample(0));
    dc = done_cnt;
    start_batch(6);
    bus.start = 1'b1;
    bus.n_samples = CNT_W'(2);
    feed(0);
    bus.start = 1'b0;
    wait_done("busy_start", 20);
    verify("busy_start", 6);
    finish_done("busy_start", dc);

    // Extremes, one sample each.
    stim_q.push_back({16'd0, 16'd0, 17'd131071});
    start_batch(1);
    feed(0);
    wait_done("ext_hi", 20);
    verify("ext_hi", 1);
    check("ext_hi.wce_k", bus.wce, 131071);
    stim_q.push_back({16'd65535, 16'd65535, 17'd0});
    start_batch(1);
    feed(0);
    wait_done("ext_lo", 20);
    verify("ext_lo", 1);
    check("ext_lo.sse_k", longint'($signed(bus.sse)), -131070);

    // Random errors: the 18-bit build saturates along the way.
    for (int i = 0; i < 300; i++) stim_q.push_back(rnd_sample($urandom_range(0, 3) == 0));
    start_batch(300);
    feed(0);
    wait_done("rand", 50);
    verify("rand", 300);

    // Saturation, then a negative sample that must not pull sse off its clamp.
    for (int i = 0; i < 3; i++) stim_q.push_back({16'd0, 16'd0, 17'd131071});
    stim_q.push_back({16'd65535, 16'd65535, 17'd0});
    start_batch(4);
    feed(0);
    wait_done("sat", 20);
    verify("sat", 4);
    check("sat.s18.sae_k", bus_s.sae, 262143);
    check("sat.s18.sse_k", longint'($signed(bus_s.sse)), 131071);

    // Reset in the middle of a batch.
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) stim_q.push_back(rnd_sample(0));
    start_batch(10);
    bus.in_valid = 1'b1;
    {bus.in_a, bus.in_b, bus.in_approx} = {16'd1, 16'd2, 17'd9};
    repeat (4) @(negedge clk);
    dc = done_cnt;
    rst_n = 1'b0;
    #1;
    check("mid_rst.sample_cnt", bus.sample_cnt, 0);
    check("mid_rst.sae", bus.sae, 0);
    check("mid_rst.busy", bus.busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("mid_rst.in_ready", bus.in_ready, 0);
    check("mid_rst.state", dbg_state, 0);
    check("mid_rst.sample_cnt_after", bus.sample_cnt, 0);
    check("mid_rst.err_cnt_after", bus.err_cnt, 0);
    check("mid_rst.sse_after", bus.sse, 0);
    check("mid_rst.no_done", done_cnt - dc, 0);
    bus.in_valid = 1'b0;
    stim_q.delete();

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
